// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED pattern controller: mode codes, widths and
// the mode rotation order.
package led_ctrl_pkg;

   localparam int MODE_W = 2;
   localparam int PAT_W  = 8;
   localparam int PWM_W  = 8;

   typedef enum logic [MODE_W-1:0] {
      MODE_COUNT   = 2'd0,
      MODE_SCAN    = 2'd1,
      MODE_BREATHE = 2'd2,
      MODE_OFF     = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   function automatic mode_e next_mode(input mode_e m);
      case (m)
         MODE_COUNT:   return MODE_SCAN;
         MODE_SCAN:    return MODE_BREATHE;
         MODE_BREATHE: return MODE_OFF;
         default:      return MODE_COUNT;
      endcase
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button synchronizer and debouncer; PRESS is a single-cycle pulse on each
// accepted press. A button already held when reset ends must be released first.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 240000
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic BTN,
   output logic PRESS
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       r_sync;
   logic [1:0]       r_valid;
   logic             r_stable;
   logic             r_armed;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;
   logic             w_differs;
   logic             w_accept;

   // r_valid masks the two cycles in which the synchronizer still holds reset data
   assign w_differs = r_valid[1] && (r_sync[1] != r_stable);
   assign w_accept  = w_differs && (r_cnt == CNT_LAST);

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // pre-edge values, independent of statement order.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_sync   <= '0;
         r_valid  <= '0;
         r_stable <= 1'b0;
         r_armed  <= 1'b0;
         r_press  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync  <= {r_sync[0], BTN};
         r_valid <= {r_valid[0], 1'b1};
         r_press <= w_accept && r_sync[1] && r_armed;
         if (r_valid[1] && !r_sync[1])
            r_armed <= 1'b1;
         if (w_accept) begin
            r_stable <= r_sync[1];
            r_cnt    <= '0;
         end else if (w_differs) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign PRESS = r_press;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Button-selected LED pattern generator: binary count, bouncing dot, PWM breathe
// and off, stepped by a prescaled tick. All outputs are registered.
module led_pattern_ctrl
   import led_ctrl_pkg::*;
#(
   parameter int TICK_DIV        = 1200000,
   parameter int DEBOUNCE_CYCLES = 240000
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              BTN,
   output logic [PAT_W-1:0]  D,
   output logic              LED,
   output logic [MODE_W-1:0] MODE
);

   localparam int PRESC_W = $clog2(TICK_DIV);
   localparam int POS_W   = $clog2(PAT_W);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [POS_W-1:0]   POS_MAX    = POS_W'(PAT_W - 1);
   localparam logic [PWM_W-1:0]   DUTY_MAX   = '1;

   mode_e              r_mode,  w_mode_nxt;
   dir_e               r_dir,   w_dir_nxt;
   logic [PRESC_W-1:0] r_presc, w_presc_nxt;
   logic [PAT_W-1:0]   r_count, w_count_nxt;
   logic [POS_W-1:0]   r_pos,   w_pos_nxt;
   logic [PWM_W-1:0]   r_duty,  w_duty_nxt;
   logic [PWM_W-1:0]   r_pwm,   w_pwm_nxt;
   logic [PAT_W-1:0]   r_d,     w_d_nxt;
   logic               r_led,   w_led_nxt;
   logic               w_press;
   logic               w_tick;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .CLK   (CLK),
      .RST_N (RST_N),
      .BTN   (BTN),
      .PRESS (w_press)
   );

   // The prescaler is held at 0 in OFF, so no tick can fire there
   assign w_tick    = (r_presc == PRESC_LAST);
   assign w_pwm_nxt = r_pwm + PWM_W'(1);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_mode  <= MODE_COUNT;
         r_dir   <= DIR_UP;
         r_presc <= '0;
         r_count <= '0;
         r_pos   <= '0;
         r_duty  <= '0;
         r_pwm   <= '0;
         r_d     <= '0;
         r_led   <= 1'b0;
      end else begin
         r_mode  <= w_mode_nxt;
         r_dir   <= w_dir_nxt;
         r_presc <= w_presc_nxt;
         r_count <= w_count_nxt;
         r_pos   <= w_pos_nxt;
         r_duty  <= w_duty_nxt;
         r_pwm   <= w_pwm_nxt;
         r_d     <= w_d_nxt;
         r_led   <= w_led_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path leaves a
      // signal unassigned, which would otherwise infer a latch.
      w_mode_nxt  = r_mode;
      w_dir_nxt   = r_dir;
      w_presc_nxt = r_presc;
      w_count_nxt = r_count;
      w_pos_nxt   = r_pos;
      w_duty_nxt  = r_duty;
      w_led_nxt   = r_led;
      w_d_nxt     = '0;

      // An advance restarts the pattern and swallows a coincident tick
      if (w_press) begin
         w_mode_nxt  = next_mode(r_mode);
         w_dir_nxt   = DIR_UP;
         w_presc_nxt = '0;
         w_count_nxt = '0;
         w_pos_nxt   = '0;
         w_duty_nxt  = '0;
         if (w_mode_nxt == MODE_OFF)
            w_led_nxt = 1'b0;
      end else if (r_mode == MODE_OFF) begin
         w_presc_nxt = '0;
         w_led_nxt   = 1'b0;
      end else begin
         w_presc_nxt = w_tick ? '0 : r_presc + PRESC_W'(1);
         if (w_tick) begin
            w_led_nxt = ~r_led;
            case (r_mode)
               MODE_COUNT: w_count_nxt = r_count + PAT_W'(1);
               MODE_SCAN: begin
                  if (r_dir == DIR_UP) begin
                     if (r_pos == POS_MAX) begin
                        w_pos_nxt = r_pos - POS_W'(1);
                        w_dir_nxt = DIR_DOWN;
                     end else begin
                        w_pos_nxt = r_pos + POS_W'(1);
                     end
                  end else if (r_pos == '0) begin
                     w_pos_nxt = POS_W'(1);
                     w_dir_nxt = DIR_UP;
                  end else begin
                     w_pos_nxt = r_pos - POS_W'(1);
                  end
               end
               MODE_BREATHE: begin
                  if (r_dir == DIR_UP) begin
                     if (r_duty == DUTY_MAX) begin
                        w_duty_nxt = r_duty - PWM_W'(1);
                        w_dir_nxt  = DIR_DOWN;
                     end else begin
                        w_duty_nxt = r_duty + PWM_W'(1);
                     end
                  end else if (r_duty == '0) begin
                     w_duty_nxt = PWM_W'(1);
                     w_dir_nxt  = DIR_UP;
                  end else begin
                     w_duty_nxt = r_duty - PWM_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end

      // D is built from next-state values so it changes on the edge after a tick
      case (w_mode_nxt)
         MODE_COUNT:   w_d_nxt = w_count_nxt;
         MODE_SCAN:    w_d_nxt = PAT_W'(1) << w_pos_nxt;
         MODE_BREATHE: w_d_nxt = {PAT_W{w_pwm_nxt < w_duty_nxt}};
         default:      w_d_nxt = '0;
      endcase
   end

   assign D    = r_d;
   assign LED  = r_led;
   assign MODE = r_mode;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3:
// directed scenarios with literal expectations plus a random button/reset phase.
module tb_led_pattern_ctrl;

   localparam int TD = 4;
   localparam int DB = 3;

   logic       CLK   = 1'b0;
   logic       RST_N = 1'b0;
   logic       BTN   = 1'b0;
   logic [7:0] D;
   logic       LED;
   logic [1:0] MODE;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   led_pattern_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .BTN   (BTN),
      .D     (D),
      .LED   (LED),
      .MODE  (MODE)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   // m_n   : rising edges since reset (free-running PWM phase)
   // m_c   : edges spent in the current mode since it was entered
   // m_led0: LED value at mode entry; each elapsed tick flips it
   int m_n, m_mode, m_c, m_led0, m_acc, m_armed, m_press;
   int m_smp[$];
   int m_run[$];

   function automatic int tri_wave(input int k, input int top);
      int m;
      m = k % (2 * top);
      return (m <= top) ? m : 2 * top - m;
   endfunction

   function automatic int m_led_f();
      if (m_mode == 3) return 0;
      return m_led0 ^ ((m_c / TD) & 1);
   endfunction

   function automatic logic [7:0] m_d_f();
      int k;
      k = m_c / TD;
      case (m_mode)
         0:       return 8'(k % 256);
         1:       return 8'(1 << tri_wave(k, 7));
         2:       return ((m_n % 256) < tri_wave(k, 255)) ? 8'hFF : 8'h00;
         default: return 8'h00;
      endcase
   endfunction

   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_n = 0; m_mode = 0; m_c = 0; m_led0 = 0;
         m_acc = 0; m_armed = 0; m_press = 0;
         m_smp.delete();
         m_run.delete();
      end else begin
         int s;
         int cur_led;
         bit same;
         m_n++;
         if (m_press != 0) begin
            cur_led = m_led_f();
            m_mode  = (m_mode + 1) % 4;
            m_c     = 0;
            m_led0  = (m_mode == 3) ? 0 : cur_led;
         end else if (m_mode != 3) begin
            m_c++;
         end
         m_press = 0;
         m_smp.push_back(int'(BTN));
         if (m_smp.size() > 3) void'(m_smp.pop_front());
         if (m_n >= 3) begin
            s = m_smp[0];                      // button level from two edges back
            m_run.push_back(s);
            if (m_run.size() > DB) void'(m_run.pop_front());
            same = 1'b1;
            foreach (m_run[i]) if (m_run[i] != s) same = 1'b0;
            if (m_run.size() == DB && same && s != m_acc) begin
               m_acc   = s;
               m_press = (s == 1 && m_armed != 0) ? 1 : 0;
               m_run.delete();
            end
            if (s == 0) m_armed = 1;
         end
      end
   end

   always @(negedge CLK) begin
      if (chk_en) begin
         check("model_D", D, m_d_f());
         check("model_LED", LED, m_led_f());
         check("model_MODE", MODE, m_mode);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_mode(input logic [1:0] target, input int budget, input string name);
      int i;
      i = 0;
      while (MODE !== target && i < budget) begin
         @(negedge CLK);
         i++;
      end
      check(name, MODE, target);
   endtask

   task automatic press_to(input logic [1:0] target, input string name);
      BTN = 1'b1;
      wait_mode(target, 20, name);
      BTN = 1'b0;
      repeat (8) @(negedge CLK);
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #1 RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_D", D, 8'h00);
      check("rst_LED", LED, 0);
      check("rst_MODE", MODE, 0);
      #1 RST_N = 1'b1;
   endtask

   logic [7:0] scan_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
   logic [7:0] dlog [60];
   logic [1:0] mlog [60];

   initial begin
      int first, changes, hi2, hi3, six, adv, i;
      logic [7:0] prev;

      repeat (3) @(negedge CLK);
      chk_en = 1'b1;
      check("reset_D", D, 8'h00);
      check("reset_LED", LED, 0);
      check("reset_MODE", MODE, 0);

      // count mode from reset: one step and one LED toggle every 4 cycles
      #1 RST_N = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge CLK);
         if (k == 6)  begin check("count_D_e6", D, 8'h01);  check("count_LED_e6", LED, 1); end
         if (k == 13) begin check("count_D_e13", D, 8'h03); check("count_LED_e13", LED, 1); end
         if (k == 40) begin
            check("count_D_e40", D, 8'h0A);
            check("count_LED_e40", LED, 0);
            check("count_MODE", MODE, 0);
         end
      end

      // 10-cycle press: exactly one advance, then the bouncing dot
      BTN = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge CLK);
         if (k == 10) BTN = 1'b0;
         dlog[k] = D;
         mlog[k] = MODE;
      end
      first = -1;
      changes = 0;
      for (int k = 0; k < 60; k++) begin
         if (first < 0 && mlog[k] == 2'd1) first = k;
         if (k > 0 && mlog[k] != mlog[k-1]) changes++;
      end
      check("scan_advance_count", changes, 1);
      if (first < 0 || first > 20) begin
         check("scan_entry_seen", 0, 1);
      end else begin
         check("scan_entry_D", dlog[first], 8'h01);
         prev = 8'h01;
         for (int j = 1; j <= 8; j++) begin
            check("scan_hold", dlog[first + 4*j - 1], prev);
            check("scan_step", dlog[first + 4*j], scan_exp[j-1]);
            prev = scan_exp[j-1];
         end
      end

      // bounce shorter than the debounce window never advances
      for (int k = 0; k < 20; k++) begin
         BTN = ((k / 2) % 2 == 0);
         @(negedge CLK);
      end
      BTN = 1'b0;
      repeat (10) @(negedge CLK);
      check("bounce_no_advance", MODE, 1);

      // enter BREATHE so that duty=3 lines up with PWM phase 0..3
      i = 0;
      while ((m_n % 256) != 238 && i < 300) begin
         @(negedge CLK);
         i++;
      end
      BTN = 1'b1;
      wait_mode(2'd2, 20, "breathe_entry");
      BTN = 1'b0;
      check("breathe_duty0_D", D, 8'h00);
      hi2 = 0;
      hi3 = 0;
      for (int j = 1; j <= 15; j++) begin
         @(negedge CLK);
         if (j >= 8  && j <= 11 && D == 8'hFF) hi2++;
         if (j >= 12 && j <= 15 && D == 8'hFF) hi3++;
      end
      check("breathe_duty2_high", hi2, 0);
      check("breathe_duty3_high", hi3, 3);
      repeat (2100) @(negedge CLK);

      // OFF: dark, LED low; then wrap back to COUNT
      press_to(2'd3, "off_entry");
      check("off_D", D, 8'h00);
      check("off_LED", LED, 0);
      press_to(2'd0, "wrap_to_count");

      // press lands on the tick that would take count 5->6
      do_reset();
      six = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge CLK);
         if (D == 8'h06) six++;
         if (k == 18) BTN = 1'b1;
         if (k == 23) begin check("coinc_pre_D", D, 8'h05); check("coinc_pre_MODE", MODE, 0); end
         if (k == 24) begin check("coinc_MODE", MODE, 1);   check("coinc_D", D, 8'h01); end
      end
      check("coinc_no_06", six, 0);

      // reset mid-SCAN with the button held: no advance until re-pressed
      do_reset();
      adv = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge CLK);
         if (MODE != 2'd0) adv++;
      end
      check("held_btn_no_advance", adv, 0);
      check("held_btn_D", D, 8'h07);
      BTN = 1'b0;
      repeat (10) @(negedge CLK);
      press_to(2'd1, "repress_advance");

      // random button activity with occasional resets
      for (int seg = 0; seg < 400; seg++) begin
         if ($urandom_range(0, 39) == 0) do_reset();
         BTN = 1'($urandom_range(0, 1));
         repeat ($urandom_range(1, 10)) @(negedge CLK);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not reach its summary");
      $fatal(1, "timeout");
   end

endmodule
